instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 161 ++++++++++++++++
 tb/tb_instr_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation, credit-limited instruction memory requests,
// in-order response buffering and redirect flushing toward the decode stage.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op_code,
  output logic [2:0]  func3,
  output logic        func7b6
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   stale_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   fifo_rd_q, fifo_wr_q;
  logic [PW-1:0]   pcq_rd_q, pcq_wr_q;
  entry_t          fifo_mem [DEPTH];
  logic [31:0]     pcq_mem  [DEPTH];

  logic            in_run;
  logic [CW:0]     inflight;
  logic            req_fire;
  logic            fifo_push;
  logic            fifo_pop;
  logic [CW-1:0]   stale_on_redirect;
  logic [31:0]     target_aligned;
  entry_t          head;
  logic            unused_target_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_target_bits = ^pc_target[1:0];
  assign target_aligned     = {pc_target[31:2], 2'b00};
  assign in_run             = (state_q == RUN);
  assign inflight           = {1'b0, outstanding_q} + {1'b0, count_q};
  assign req_fire           = imem_req_valid & imem_req_ready;
  // A response that coincides with a redirect belongs to the old path and is dropped.
  assign fifo_push          = in_run & imem_rsp_valid & ~pc_src;
  assign fifo_pop           = instr_valid & instr_ready;
  assign stale_on_redirect  = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
  assign head               = fifo_mem[fifo_rd_q];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; combinational blocks use blocking assignments with defaults first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (pc_src && (stale_on_redirect != '0)) state_d = DRAIN;
      end
      DRAIN: begin
        if (imem_rsp_valid && (stale_q == CW'(1))) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Request valid is gated by rst_n so the bus stays idle while reset is held.
  always_comb begin
    imem_req_valid = rst_n & in_run & (inflight < {1'b0, DEPTH_C});
    imem_req_addr  = fetch_pc_q;
    instr_valid    = (count_q != '0);
    instr          = instr_valid ? head.word : 32'h0;
    instr_pc       = instr_valid ? head.pc   : 32'h0;
  end

  assign op_code = instr[6:0];
  assign func3   = instr[14:12];
  assign func7b6 = instr[30];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
      count_q       <= '0;
      fifo_rd_q     <= '0;
      fifo_wr_q     <= '0;
      pcq_rd_q      <= '0;
      pcq_wr_q      <= '0;
    end else if (in_run) begin
      if (pc_src) begin
        fetch_pc_q    <= target_aligned;
        stale_q       <= stale_on_redirect;
        outstanding_q <= '0;
        count_q       <= '0;
        fifo_rd_q     <= '0;
        fifo_wr_q     <= '0;
        pcq_rd_q      <= '0;
        pcq_wr_q      <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
          pcq_wr_q   <= ptr_inc(pcq_wr_q);
        end
        if (imem_rsp_valid) pcq_rd_q <= ptr_inc(pcq_rd_q);
        outstanding_q <= outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (fifo_push) fifo_wr_q <= ptr_inc(fifo_wr_q);
        if (fifo_pop)  fifo_rd_q <= ptr_inc(fifo_rd_q);
        count_q <= count_q + CW'(fifo_push) - CW'(fifo_pop);
      end
    end else begin
      // Draining: the buffer is already empty; only the target and stale count move.
      if (pc_src) fetch_pc_q <= target_aligned;
      if (imem_rsp_valid && (stale_q != '0)) stale_q <= stale_q - CW'(1);
    end
  end

  // NOTE: storage arrays carry no reset; pointers and count define which entries are
  // meaningful, and the outputs are forced to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (in_run && req_fire) pcq_mem[pcq_wr_q] <= fetch_pc_q;
    if (fifo_push) fifo_mem[fifo_wr_q] <= '{word: imem_rsp_data, pc: pcq_mem[pcq_rd_q]};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_push |-> ((count_q < DEPTH_C) || fifo_pop));

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (in_run ? (outstanding_q != '0) : (stale_q != '0)));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: in-order memory model with a response hold control,
// hand-derived expectations for streaming, stall, redirect, field slicing, wrap and reset.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op_code;
  logic [2:0]  func3;
  logic        func7b6;

  int checks   = 0;
  int failures = 0;

  logic        rsp_hold;
  logic [31:0] pend_q [$];

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc_src         (pc_src),
    .pc_target      (pc_target),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op_code        (op_code),
    .func3          (func3),
    .func7b6        (func7b6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a == 32'h0000_0200) ? 32'h40B5_0533 : (a ^ 32'hDEAD_0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory: records accepted addresses mid-cycle, answers in order from the next cycle.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) pend_q.push_back(imem_req_addr);
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pend_q.delete();
        imem_rsp_valid = 1'b0;
      end else if (!rsp_hold && pend_q.size() > 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_of(pend_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Collect n delivered instructions; each must carry the next sequential PC and its word.
  task automatic run_expect(input int n, input logic [31:0] start_pc, input int budget, input string tag);
    logic [31:0] exp_pc;
    int got;
    int cyc;
    exp_pc = start_pc;
    got    = 0;
    cyc    = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        check({tag, "_pc"}, instr_pc, exp_pc);
        check({tag, "_word"}, instr, word_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      step();
      cyc++;
    end
    check({tag, "_delivered"}, got, n);
  endtask

  initial begin
    int fires;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    pc_src         = 1'b0;
    pc_target      = 32'h0;
    instr_ready    = 1'b0;
    rsp_hold       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_op_code", {25'h0, op_code}, 32'h0);

    // Streaming with a one-cycle memory
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    do_reset();
    @(negedge clk);
    check("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("first_req_addr", imem_req_addr, 32'h0);
    step();
    run_expect(6, 32'h0, 40, "stream");

    // Decode stall: exactly DEPTH requests, then release and drain in order
    instr_ready = 1'b0;
    do_reset();
    fires = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) fires++;
      step();
    end
    @(negedge clk);
    check("stall_fires", fires, 2);
    check("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("stall_head_valid", {31'h0, instr_valid}, 32'h1);
    check("stall_head_pc", instr_pc, 32'h0);
    step();
    instr_ready = 1'b1;
    run_expect(4, 32'h0, 40, "unstall");

    // Redirect with two requests outstanding
    rsp_hold = 1'b1;
    do_reset();
    step();
    step();
    pc_src    = 1'b1;
    pc_target = 32'h0000_0103;
    @(negedge clk);
    check("redir_credit_block", {31'h0, imem_req_valid}, 32'h0);
    step();
    pc_src   = 1'b0;
    rsp_hold = 1'b0;
    @(negedge clk);
    check("redir_addr", imem_req_addr, 32'h0000_0100);
    check("redir_drain_valid", {31'h0, imem_req_valid}, 32'h0);
    check("redir_instr_valid", {31'h0, instr_valid}, 32'h0);
    step();
    @(negedge clk);
    check("redir_drain_valid2", {31'h0, imem_req_valid}, 32'h0);
    step();
    @(negedge clk);
    check("redir_resume_valid", {31'h0, imem_req_valid}, 32'h1);
    check("redir_resume_addr", imem_req_addr, 32'h0000_0100);
    step();
    run_expect(3, 32'h0000_0100, 40, "redir");

    // Redirect coinciding with a response and a request acceptance
    do_reset();
    step();
    pc_src    = 1'b1;
    pc_target = 32'h0000_0300;
    @(negedge clk);
    check("same_cyc_fire", {31'h0, imem_req_valid}, 32'h1);
    check("same_cyc_rsp", {31'h0, imem_rsp_valid}, 32'h1);
    step();
    pc_src = 1'b0;
    @(negedge clk);
    check("same_cyc_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("same_cyc_addr", imem_req_addr, 32'h0000_0300);
    check("same_cyc_req_valid", {31'h0, imem_req_valid}, 32'h0);
    step();
    @(negedge clk);
    check("same_cyc_resume", {31'h0, imem_req_valid}, 32'h1);
    step();
    run_expect(2, 32'h0000_0300, 40, "same_cyc");

    // Field slicing of 0x40B50533 held at the head
    instr_ready = 1'b0;
    do_reset();
    pc_src    = 1'b1;
    pc_target = 32'h0000_0200;
    step();
    pc_src = 1'b0;
    repeat (6) step();
    @(negedge clk);
    check("field_head_pc", instr_pc, 32'h0000_0200);
    check("field_instr", instr, 32'h40B5_0533);
    check("field_op_code", {25'h0, op_code}, 32'h0000_0033);
    check("field_func3", {29'h0, func3}, 32'h0);
    check("field_func7b6", {31'h0, func7b6}, 32'h1);
    step();

    // PC wrap past 0xFFFF_FFFC
    instr_ready = 1'b1;
    do_reset();
    pc_src    = 1'b1;
    pc_target = 32'hFFFF_FFFF;
    step();
    pc_src = 1'b0;
    run_expect(3, 32'hFFFF_FFFC, 40, "wrap");

    // Asynchronous reset mid-burst
    instr_ready = 1'b0;
    do_reset();
    repeat (6) step();
    @(negedge clk);
    check("midrst_pre_valid", {31'h0, instr_valid}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("midrst_req_addr", imem_req_addr, 32'h0);
    check("midrst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("midrst_instr", instr, 32'h0);
    check("midrst_instr_pc", instr_pc, 32'h0);
    check("midrst_func7b6", {31'h0, func7b6}, 32'h0);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
